// File: rtl/imem_uart_loader.sv
// UART boot loader: parses SYNC | LEN(be16) | N x 32-bit LE words | CSUM and writes words to instruction memory.
// Holds the CPU in reset while a frame is in flight or after a failed load, until a good frame completes.
module imem_uart_loader #(
   parameter int         CLKS_PER_BIT = 868,
   parameter int         NUM_WORDS    = 8192,
   parameter logic [7:0] SYNC_BYTE    = 8'hA5,
   parameter int         TIMEOUT_CLKS = 10_000_000
) (
   input  logic        clk,
   input  logic        arst_n,
   input  logic        uart_rx,
   output logic        we,
   output logic [31:2] waddr,
   output logic [31:0] wdat,
   output logic        cpu_rst_n,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam int BCW = $clog2(CLKS_PER_BIT + 1);
   localparam int TCW = $clog2(TIMEOUT_CLKS + 1);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, CSUM} state_t;

   // ---------------- receiver ----------------
   logic [1:0]     sync_q;
   logic           rx_s, rx_prev_q;
   rx_state_t      rx_state_q, rx_state_d;
   logic [BCW-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]     rx_bit_q, rx_bit_d;
   logic [7:0]     rx_sh_q, rx_sh_d;
   logic           byte_vld, frm_err;

   assign rx_s = sync_q[1];

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         sync_q     <= 2'b11;
         rx_prev_q  <= 1'b1;
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_sh_q    <= '0;
      end else begin
         sync_q     <= {sync_q[0], uart_rx};
         rx_prev_q  <= rx_s;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_sh_q    <= rx_sh_d;
      end
   end

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_sh_d    = rx_sh_q;
      byte_vld   = 1'b0;
      frm_err    = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            if (rx_prev_q && !rx_s) begin
               rx_state_d = RX_START;
               rx_cnt_d   = '0;
            end
         end
         RX_START: begin
            // a start bit that is high again at mid-bit was a glitch
            if (rx_cnt_q == BCW'(CLKS_PER_BIT / 2 - 1)) begin
               rx_cnt_d   = '0;
               rx_bit_d   = '0;
               rx_state_d = rx_s ? RX_IDLE : RX_DATA;
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         RX_DATA: begin
            if (rx_cnt_q == BCW'(CLKS_PER_BIT - 1)) begin
               rx_cnt_d = '0;
               rx_sh_d  = {rx_s, rx_sh_q[7:1]};
               if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
               else                  rx_bit_d   = rx_bit_q + 1'b1;
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         RX_STOP: begin
            if (rx_cnt_q == BCW'(CLKS_PER_BIT - 1)) begin
               rx_cnt_d   = '0;
               rx_state_d = RX_IDLE;
               byte_vld   = rx_s;
               frm_err    = !rx_s;
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
      endcase
   end

   // ---------------- frame parser ----------------
   state_t         state_q, state_d;
   logic [15:0]    len_q, len_d, idx_q, idx_d, n_w;
   logic [7:0]     csum_q, csum_d;
   logic [23:0]    word_q, word_d;
   logic [1:0]     bcnt_q, bcnt_d;
   logic [TCW-1:0] tmo_q, tmo_d;
   logic           we_q, we_d, done_q, done_d, err_q, err_d, bad_q, bad_d;
   logic           cpu_rst_n_q, cpu_rst_n_d;
   logic [29:0]    waddr_q, waddr_d;
   logic [31:0]    wdat_q, wdat_d;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q     <= IDLE;
         len_q       <= '0;
         idx_q       <= '0;
         csum_q      <= '0;
         word_q      <= '0;
         bcnt_q      <= '0;
         tmo_q       <= '0;
         we_q        <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         bad_q       <= 1'b0;
         cpu_rst_n_q <= 1'b0;
         waddr_q     <= '0;
         wdat_q      <= '0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         idx_q       <= idx_d;
         csum_q      <= csum_d;
         word_q      <= word_d;
         bcnt_q      <= bcnt_d;
         tmo_q       <= tmo_d;
         we_q        <= we_d;
         done_q      <= done_d;
         err_q       <= err_d;
         bad_q       <= bad_d;
         cpu_rst_n_q <= cpu_rst_n_d;
         waddr_q     <= waddr_d;
         wdat_q      <= wdat_d;
      end
   end

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      idx_d   = idx_q;
      csum_d  = csum_q;
      word_d  = word_q;
      bcnt_d  = bcnt_q;
      tmo_d   = '0;
      we_d    = 1'b0;
      done_d  = 1'b0;
      err_d   = err_q;
      bad_d   = bad_q;
      waddr_d = waddr_q;
      wdat_d  = wdat_q;
      n_w     = {len_q[15:8], rx_sh_q};
      if (state_q != IDLE && !byte_vld) tmo_d = tmo_q + 1'b1;

      if (frm_err) begin
         err_d   = 1'b1;
         bad_d   = bad_q || (state_q != IDLE);
         state_d = IDLE;
      end else if (state_q != IDLE && !byte_vld && tmo_q == TCW'(TIMEOUT_CLKS - 1)) begin
         err_d   = 1'b1;
         bad_d   = 1'b1;
         state_d = IDLE;
      end else if (byte_vld) begin
         csum_d = csum_q + rx_sh_q;
         case (state_q)
            IDLE: begin
               if (rx_sh_q == SYNC_BYTE) begin
                  state_d = LEN_HI;
                  err_d   = 1'b0;
                  csum_d  = '0;
                  idx_d   = '0;
                  bcnt_d  = '0;
               end
            end
            LEN_HI: begin
               len_d[15:8] = rx_sh_q;
               state_d     = LEN_LO;
            end
            LEN_LO: begin
               len_d = n_w;
               if (32'(n_w) > 32'(NUM_WORDS)) begin
                  err_d   = 1'b1;
                  bad_d   = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = (n_w == 16'd0) ? CSUM : DATA;
               end
            end
            DATA: begin
               word_d = {rx_sh_q, word_q[23:8]};
               bcnt_d = bcnt_q + 1'b1;
               if (bcnt_q == 2'd3) begin
                  we_d    = 1'b1;
                  waddr_d = 30'(idx_q);
                  wdat_d  = {rx_sh_q, word_q};
                  idx_d   = idx_q + 1'b1;
                  if (idx_q == len_q - 16'd1) state_d = CSUM;
               end
            end
            CSUM: begin
               state_d = IDLE;
               if (rx_sh_q == csum_q) begin
                  done_d = 1'b1;
                  bad_d  = 1'b0;
               end else begin
                  err_d = 1'b1;
                  bad_d = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
      // registered from next-state so it tracks busy cycle-for-cycle
      cpu_rst_n_d = (state_d == IDLE) && !bad_d;
   end

   assign we        = we_q;
   assign waddr     = waddr_q;
   assign wdat      = wdat_q;
   assign done      = done_q;
   assign err       = err_q;
   assign busy      = (state_q != IDLE);
   assign cpu_rst_n = cpu_rst_n_q;

endmodule
